// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder: SPI mode-3 slave over a 64x8 register file.
// Optional 3-wire pad sharing under `define SPI_3WIRE_EN.
module gsensor_spi_responder #(
  parameter logic [7:0] DEVID    = 8'hE5,
  parameter int         SYNC_STG = 2
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RESET,
  input  logic       SPI_CS_N,
  input  logic       SPI_SCLK,
  input  logic       SPI_SDI,
  output logic       SPI_SDO,
  output logic       SPI_SDO_OE,
  input  logic       LOC_WE,
  input  logic [5:0] LOC_ADDR,
  input  logic [7:0] LOC_WDATA,
  output logic       WR_STROBE,
  output logic [5:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       WR_COLLISION,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE, CMD, RDATA, WDATA
  } state_t;

  logic [SYNC_STG-1:0] sclk_sr, cs_sr, sdi_sr;
  logic sclk_s, cs_s, sdi_s;
  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [5:0] addr_q, addr_d;
  logic mb_q, mb_d;
  logic sdo_q, sdo_d;
  logic load_q, load_d;
  logic wreq_q, wreq_d;
  logic [5:0] wadr_q, wadr_d;
  logic [7:0] wdat_q, wdat_d;

  logic [7:0] regs [64];
  logic [7:0] byte_in, rd_byte;
  logic collide;

  // SPI pin synchronizers plus one history flop for edge detection
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      sclk_sr <= '1;
      cs_sr   <= '1;
      sdi_sr  <= '0;
      sclk_q  <= 1'b1;
      cs_q    <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STG-2:0], SPI_SCLK};
      cs_sr   <= {cs_sr[SYNC_STG-2:0], SPI_CS_N};
      sdi_sr  <= {sdi_sr[SYNC_STG-2:0], SPI_SDI};
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STG-1];
  assign cs_s      = cs_sr[SYNC_STG-1];
  assign sdi_s     = sdi_sr[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign byte_in   = {shift_q, sdi_s};
  assign rd_byte   = regs[addr_q];
  assign BUSY      = ~cs_s;
  assign SPI_SDO   = sdo_q;

  // FSM and shifter state register
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      mb_q    <= 1'b0;
      sdo_q   <= 1'b0;
      load_q  <= 1'b0;
      wreq_q  <= 1'b0;
      wadr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      mb_q    <= mb_d;
      sdo_q   <= sdo_d;
      load_q  <= load_d;
      wreq_q  <= wreq_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
    end
  end

  // next-state: command decode, read shift-out, write capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    mb_d    = mb_q;
    sdo_d   = sdo_q;
    load_d  = load_q;
    wreq_d  = 1'b0;
    wadr_d  = addr_q;
    wdat_d  = byte_in;
    if (cs_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      sdo_d   = 1'b0;
      load_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_q) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              mb_d    = byte_in[6];
              addr_d  = byte_in[5:0];
              load_d  = 1'b1;
              state_d = byte_in[7] ? RDATA : WDATA;
            end
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            if (load_q) begin
              shift_d = rd_byte[6:0];
              sdo_d   = rd_byte[7];
              load_d  = 1'b0;
            end else begin
              shift_d = {shift_q[5:0], 1'b0};
              sdo_d   = shift_q[6];
            end
          end else if (sclk_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              load_d = 1'b1;
              if (mb_q) addr_d = addr_q + 6'd1;
            end
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wreq_d = (addr_q != 6'd0);
              if (mb_q) addr_d = addr_q + 6'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign collide = wreq_q && LOC_WE && (LOC_ADDR == wadr_q);

  // register file; the local port wins a same-address race
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 64; i++)
        regs[i] <= (i == 0) ? DEVID : 8'h00;
      WR_STROBE    <= 1'b0;
      WR_COLLISION <= 1'b0;
      WR_ADDR      <= '0;
      WR_DATA      <= '0;
    end else begin
      WR_STROBE    <= wreq_q && !collide;
      WR_COLLISION <= collide;
      if (wreq_q && !collide) begin
        regs[wadr_q] <= wdat_q;
        WR_ADDR      <= wadr_q;
        WR_DATA      <= wdat_q;
      end
      if (LOC_WE && LOC_ADDR != 6'd0)
        regs[LOC_ADDR] <= LOC_WDATA;
    end
  end

`ifdef SPI_3WIRE_EN
  logic oe_q;

  // drive the shared pad only from the first read-data fall to CS_N rise
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET)
      oe_q <= 1'b0;
    else if (cs_s)
      oe_q <= 1'b0;
    else if (state_q == RDATA && sclk_fall && load_q)
      oe_q <= 1'b1;
  end

  assign SPI_SDO_OE = oe_q;
`else
  assign SPI_SDO_OE = ~cs_s;
`endif

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// tb_gsensor_spi_responder: directed SPI master with scoreboards.
// Read bytes and write strobes are checked against queued expectations.
module tb_gsensor_spi_responder;

  localparam int HALF = 8;
  localparam int SYNC = 2;
`ifdef SPI_3WIRE_EN
  localparam bit THREE = 1'b1;
`else
  localparam bit THREE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cs_n, sclk, sdi;
  logic sdo, sdo_oe;
  logic loc_we;
  logic [5:0] loc_addr;
  logic [7:0] loc_wdata;
  logic wr_strobe, wr_coll, busy;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int coll_cnt = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;

  logic coll_arm = 1'b0;
  logic [5:0] coll_addr = '0;
  logic [7:0] coll_data = '0;

  logic [7:0] rd_q [$];
  logic [13:0] wr_q [$];

  gsensor_spi_responder dut (
    .MAX10_CLK1_50(clk),
    .RESET(rst),
    .SPI_CS_N(cs_n),
    .SPI_SCLK(sclk),
    .SPI_SDI(sdi),
    .SPI_SDO(sdo),
    .SPI_SDO_OE(sdo_oe),
    .LOC_WE(loc_we),
    .LOC_ADDR(loc_addr),
    .LOC_WDATA(loc_wdata),
    .WR_STROBE(wr_strobe),
    .WR_ADDR(wr_addr),
    .WR_DATA(wr_data),
    .WR_COLLISION(wr_coll),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // strobe monitor pops the write scoreboard
  always @(negedge clk) begin
    if (wr_coll) coll_cnt++;
    if (wr_strobe) begin
      strobe_cnt++;
      checks++;
      assert (wr_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe: observed %h/%h expected none",
               wr_addr, wr_data);
      end
      if (wr_q.size() != 0) begin
        check("strobe_addr_data", {2'b00, wr_addr, wr_data},
              {2'b00, wr_q.pop_front()});
        check("strobe_latency", 16'(cyc - rise_cyc),
              16'(SYNC + 2));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx,
                      output logic oe_and, output logic oe_or,
                      output logic sdo_or);
    rx = '0;
    oe_and = 1'b1;
    oe_or = 1'b0;
    sdo_or = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      sclk = 1'b0;
      sdi = tx[i];
      wait_clk(HALF);
      rx[i] = sdo;
      oe_and = oe_and & sdo_oe;
      oe_or = oe_or | sdo_oe;
      sdo_or = sdo_or | sdo;
      sclk = 1'b1;
      rise_cyc = cyc;
      if (i == 0 && coll_arm) begin
        repeat (3) @(posedge clk);
        #1;
        loc_we = 1'b1;
        loc_addr = coll_addr;
        loc_wdata = coll_data;
        wait_clk(1);
        loc_we = 1'b0;
        wait_clk(HALF - 4);
      end else begin
        wait_clk(HALF);
      end
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // command byte or write-data byte: pad quiet, SDO low
  task automatic quiet_byte(input string tag, input logic [7:0] tx);
    logic [7:0] rx;
    logic a, o, s;
    xfer(tx, 8, rx, a, o, s);
    check({tag, "_sdo"}, {15'd0, s}, 16'd0);
    check({tag, "_oe"}, {15'd0, THREE ? o : a},
          {15'd0, !THREE});
  endtask

  task automatic read_byte(input string tag);
    logic [7:0] rx;
    logic a, o, s;
    xfer(8'h00, 8, rx, a, o, s);
    check(tag, {8'd0, rx}, {8'd0, rd_q.pop_front()});
    check({tag, "_oe"}, {15'd0, a}, 16'd1);
  endtask

  task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
    loc_we = 1'b1;
    loc_addr = a;
    loc_wdata = d;
    wait_clk(1);
    loc_we = 1'b0;
    wait_clk(1);
  endtask

  task automatic end_frame(input string tag);
    cs_high();
    check({tag, "_end_oe"}, {15'd0, sdo_oe}, 16'd0);
    check({tag, "_end_sdo"}, {15'd0, sdo}, 16'd0);
    check({tag, "_end_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic [7:0] rx;
    logic a, o, s;
    rst = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b1;
    sdi = 1'b0;
    loc_we = 1'b0;
    loc_addr = '0;
    loc_wdata = '0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(4);
    check("rst_sdo", {15'd0, sdo}, 16'd0);
    check("rst_oe", {15'd0, sdo_oe}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_strobe", {15'd0, wr_strobe}, 16'd0);
    check("rst_coll", {15'd0, wr_coll}, 16'd0);
    check("rst_wr", {2'b00, wr_addr, wr_data}, 16'd0);

    // 1: DEVID read
    cs_low();
    check("t1_busy", {15'd0, busy}, 16'd1);
    quiet_byte("t1_cmd", 8'h80);
    rd_q.push_back(8'hE5);
    read_byte("t1_devid");
    end_frame("t1");
    check("t1_no_strobe", 16'(strobe_cnt), 16'd0);

    // 2: single write then read back twice without MB
    cs_low();
    quiet_byte("t2_cmd", 8'h2D);
    wr_q.push_back({6'h2D, 8'h08});
    exp_strobes++;
    quiet_byte("t2_wd", 8'h08);
    end_frame("t2w");
    check("t2_strobes", 16'(strobe_cnt), 16'(exp_strobes));
    cs_low();
    quiet_byte("t2_rcmd", 8'hAD);
    rd_q.push_back(8'h08);
    read_byte("t2_rd0");
    rd_q.push_back(8'h08);
    read_byte("t2_rd1_hold");
    end_frame("t2r");

    // MB burst write then burst read
    cs_low();
    quiet_byte("mb_cmd", 8'h7A);
    wr_q.push_back({6'h3A, 8'hA1});
    exp_strobes++;
    quiet_byte("mb_wd0", 8'hA1);
    wr_q.push_back({6'h3B, 8'hB2});
    exp_strobes++;
    quiet_byte("mb_wd1", 8'hB2);
    end_frame("mbw");
    cs_low();
    quiet_byte("mb_rcmd", 8'hFA);
    rd_q.push_back(8'hA1);
    read_byte("mb_rd0");
    rd_q.push_back(8'hB2);
    read_byte("mb_rd1");
    end_frame("mbr");

    // 3: local writes, burst read with wrap to DEVID
    loc_write(6'h3E, 8'h11);
    loc_write(6'h3F, 8'h22);
    loc_write(6'h00, 8'h77);
    cs_low();
    quiet_byte("t3_cmd", 8'hFE);
    rd_q.push_back(8'h11);
    read_byte("t3_rd3e");
    rd_q.push_back(8'h22);
    read_byte("t3_rd3f");
    rd_q.push_back(8'hE5);
    read_byte("t3_wrap");
    end_frame("t3");

    // 4: same-address collision, local wins
    cs_low();
    quiet_byte("t4_cmd", 8'h32);
    coll_arm = 1'b1;
    coll_addr = 6'h32;
    coll_data = 8'h5A;
    quiet_byte("t4_wd", 8'h11);
    coll_arm = 1'b0;
    end_frame("t4");
    check("t4_coll", 16'(coll_cnt), 16'd1);
    check("t4_strobes", 16'(strobe_cnt), 16'(exp_strobes));
    cs_low();
    quiet_byte("t4_rcmd", 8'hB2);
    rd_q.push_back(8'h5A);
    read_byte("t4_rd");
    end_frame("t4r");

    // different addresses in the same cycle: both land
    cs_low();
    quiet_byte("t4b_cmd", 8'h33);
    coll_arm = 1'b1;
    coll_addr = 6'h34;
    coll_data = 8'h44;
    wr_q.push_back({6'h33, 8'h99});
    exp_strobes++;
    quiet_byte("t4b_wd", 8'h99);
    coll_arm = 1'b0;
    end_frame("t4b");
    check("t4b_coll", 16'(coll_cnt), 16'd1);
    cs_low();
    quiet_byte("t4b_rcmd", 8'hF3);
    rd_q.push_back(8'h99);
    read_byte("t4b_rd33");
    rd_q.push_back(8'h44);
    read_byte("t4b_rd34");
    end_frame("t4br");

    // 5: aborted partial byte writes nothing
    cs_low();
    quiet_byte("t5_cmd", 8'h31);
    xfer(8'hFF, 5, rx, a, o, s);
    end_frame("t5");
    cs_low();
    quiet_byte("t5_rcmd", 8'hB1);
    rd_q.push_back(8'h00);
    read_byte("t5_rd");
    end_frame("t5r");

    // SPI write to address 0 is ignored
    cs_low();
    quiet_byte("a0_cmd", 8'h00);
    quiet_byte("a0_wd", 8'h55);
    end_frame("a0");
    cs_low();
    quiet_byte("a0_rcmd", 8'h80);
    rd_q.push_back(8'hE5);
    read_byte("a0_rd");
    end_frame("a0r");

    // reset mid-transfer clears registers, SDO low
    cs_low();
    quiet_byte("mr_cmd", 8'hAD);
    xfer(8'h00, 3, rx, a, o, s);
    rst = 1'b1;
    wait_clk(2);
    check("mr_sdo", {15'd0, sdo}, 16'd0);
    check("mr_oe", {15'd0, sdo_oe}, 16'd0);
    check("mr_busy", {15'd0, busy}, 16'd0);
    cs_n = 1'b1;
    sclk = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2 * HALF);
    check("mr_wr", {2'b00, wr_addr, wr_data}, 16'd0);
    cs_low();
    quiet_byte("mr_rcmd", 8'hED);
    rd_q.push_back(8'h00);
    read_byte("mr_rd2d");
    rd_q.push_back(8'h00);
    read_byte("mr_rd2e");
    end_frame("mrr");

    wait_clk(8);
    check("pending_strobes", 16'(wr_q.size()), 16'd0);
    check("total_strobes", 16'(strobe_cnt), 16'(exp_strobes));
    check("total_coll", 16'(coll_cnt), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
